maxnet_param: RTL and testbench
===============================

// Module: maxnet_param
// PURPOSE
// Parametrised iterative MAXNET winner-take-all engine. Finds the largest of N unsigned WIDTH-bit neuron activations by mutual inhibition.
// Returns the winner's original value and its index.
// Adds tie/timeout detection, all-zero detection and a busy flag.
// Sits after the neuron layer; the host pulses start_signal and waits for done.
// PARAMETERS
// N          4  number of neurons (>=2)
// WIDTH      5  activation width, unsigned
// EPS_SHIFT  2  inhibition weight epsilon = 2^-EPS_SHIFT
// MAX_ITER  15  iteration limit before forced termination (>=1)
// PORTS
// clock                  in   1             rising-edge clock
// reset                  in   1             synchronous, active-high
// start_signal           in   1             start request, sampled in IDLE/DONE
// neurons_in             in   N*WIDTH       neuron i at [i*WIDTH +: WIDTH]
// output_maximum_number  out  WIDTH         original input value of winner
// winner_index           out  $clog2(N)     index of winner
// done                   out  1             result valid
// busy                   out  1             iterating
// tie_timeout            out  1             MAX_ITER reached with >1 survivor
// no_winner              out  1             all activations zero at termination
// iter_count             out  $clog2(MAX_ITER+1)  iterations performed
// BEHAVIOUR
// - One clock, synchronous active-high reset: state=IDLE; all outputs and internal regs = 0.
// - States:
//   - IDLE: start_signal=1 latches neurons_in into a[] and into snapshot orig[]; iter_count<=0; next state RUN.
//   - RUN (busy=1): with nz = count of a[i]!=0:
//     - nz<=1 or iter_count==MAX_ITER -> DONE; outputs registered on this edge.
//     - otherwise update all a[i] in parallel, iter_count++, stay in RUN.
//   - DONE (done=1): outputs held. start_signal=1 relaunches as in IDLE (done drops next cycle). Otherwise stay.
// - Update rule:
//   - S = sum of a[j], width WIDTH+$clog2(N).
//   - inh_i = (S - a[i]) >> EPS_SHIFT.
//   - a[i] <= (inh_i >= a[i]) ? 0 : a[i] - inh_i.
//   - No wrap-around; result always fits WIDTH.
// - Result selection:
//   - winner = lowest index with a[i]!=0 at termination.
//   - output_maximum_number = orig[winner].
//   - If nz==0 (only possible from all-zero input): no_winner=1, winner_index=0, output_maximum_number=0.
//   - tie_timeout=1 iff termination by MAX_ITER with nz>=2.
// - Latency: start sampled at edge k. done rises after edge k+1+K, where K = iterations executed (K<=MAX_ITER).
// - start_signal ignored while busy; neurons_in only sampled at launch.
// - reset mid-RUN aborts to IDLE next edge; done/busy/flags cleared.
// TESTING
// - N=4,W=5,EPS_SHIFT=2, inputs {2,2,8,2} (idx0..3), start 1 cycle
//   -> iteration 1 gives a={0,0,7,0}
//   -> done after 2 RUN cycles, output_maximum_number=8, winner_index=2, iter_count=1, flags 0.
// - inputs {5,5,0,0}
//   -> a stalls at {3,3,0,0}
//   -> done at MAX_ITER, tie_timeout=1, winner_index=0, output_maximum_number=5, iter_count=15.
// - inputs {0,0,0,0}
//   -> done after 1 RUN cycle, no_winner=1, output_maximum_number=0, iter_count=0.
// - inputs {0,0,31,0}
//   -> immediate DONE, winner_index=2, value 31, iter_count=0.
//   Then change neurons_in while done=1 without start -> outputs unchanged.
// - Launch {9,3,12,6}; pulse start_signal mid-RUN -> ignored.
//   -> winner_index=2, value 12.
//   Relaunch; assert reset during RUN -> next cycle done=0, busy=0, all outputs 0.
// - Param sweep N=8,W=8,EPS_SHIFT=3: random unique-max vectors
//   -> winner matches reference argmax, no overflow, iter_count<=MAX_ITER.

Source files
------------

// File: rtl/maxnet_param.sv
// -----------------------------------------------------------------------------
// maxnet_param
// Iterative MAXNET winner-take-all engine. N unsigned WIDTH-bit activations
// inhibit one another each iteration with weight 2^-EPS_SHIFT until at most one
// survives or MAX_ITER iterations have run. It reports the winner's original
// (pre-inhibition) value and index, plus tie/timeout and all-zero flags.
//
// Ports
//   clock                  in   rising-edge clock
//   reset                  in   synchronous, active-high
//   start_signal           in   launch request, honoured in IDLE and DONE only
//   neurons_in             in   neuron i at [i*WIDTH +: WIDTH], sampled at launch
//   output_maximum_number  out  original input value of the winner
//   winner_index           out  index of the winner
//   done                   out  result valid, held until the next launch
//   busy                   out  iterating
//   tie_timeout            out  MAX_ITER reached with more than one survivor
//   no_winner              out  every activation zero at termination
//   iter_count             out  iterations performed
// -----------------------------------------------------------------------------
module maxnet_param #(
  parameter int N         = 4,
  parameter int WIDTH     = 5,
  parameter int EPS_SHIFT = 2,
  parameter int MAX_ITER  = 15
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start_signal,
  input  logic [N*WIDTH-1:0]            neurons_in,
  output logic [WIDTH-1:0]              output_maximum_number,
  output logic [$clog2(N)-1:0]          winner_index,
  output logic                          done,
  output logic                          busy,
  output logic                          tie_timeout,
  output logic                          no_winner,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

  localparam int IDXW = $clog2(N);
  localparam int IW   = $clog2(MAX_ITER + 1);
  localparam int NZW  = $clog2(N + 1);
  // The sum of N WIDTH-bit values needs $clog2(N) extra bits to never wrap.
  localparam int SW   = WIDTH + $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_a    [N];
  logic [WIDTH-1:0]   r_orig [N];
  logic [WIDTH-1:0]   w_upd  [N];
  logic [SW-1:0]      w_inh  [N];
  logic [SW-1:0]      w_sum;
  logic [NZW-1:0]     w_nz;
  logic [IDXW-1:0]    w_win;
  logic               w_found;
  logic               w_term;
  logic               w_done_nxt;
  logic               w_busy_nxt;

  logic [WIDTH-1:0]   r_max;
  logic [IDXW-1:0]    r_win;
  logic               r_done;
  logic               r_busy;
  logic               r_tie;
  logic               r_nw;
  logic [IW-1:0]      r_iter;

  // Sum of activations, survivor count and lowest-index survivor.
  always_comb begin
    w_sum   = '0;
    w_nz    = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_sum = w_sum + SW'(r_a[i]);
      if (r_a[i] != '0) begin
        w_nz = w_nz + NZW'(1);
      end else begin
        w_nz = w_nz;
      end
      if (!w_found && (r_a[i] != '0)) begin
        w_win   = IDXW'(i);
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Lateral inhibition; saturates at zero so a result never wraps.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_inh[i] = (w_sum - SW'(r_a[i])) >> EPS_SHIFT;
      if (w_inh[i] >= SW'(r_a[i])) begin
        w_upd[i] = '0;
      end else begin
        // inh < a here, so its low WIDTH bits hold the whole value.
        w_upd[i] = r_a[i] - w_inh[i][WIDTH-1:0];
      end
    end
  end

  assign w_term = (w_nz <= NZW'(1)) || (r_iter == IW'(MAX_ITER));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = start_signal ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_term ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = start_signal ? S_RUN : S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status flags follow the state being entered so they can be registered.
  always_comb begin
    w_done_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt = (w_state_nxt == S_RUN);
  end

  // Datapath: launch snapshot, iteration and result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_a[i]    <= '0;
        r_orig[i] <= '0;
      end
      r_max  <= '0;
      r_win  <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_tie  <= 1'b0;
      r_nw   <= 1'b0;
      r_iter <= '0;
    end else begin
      r_done <= w_done_nxt;
      r_busy <= w_busy_nxt;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_signal) begin
            for (int i = 0; i < N; i++) begin
              r_a[i]    <= neurons_in[i*WIDTH +: WIDTH];
              r_orig[i] <= neurons_in[i*WIDTH +: WIDTH];
            end
            r_iter <= '0;
          end else begin
            r_iter <= r_iter;
          end
        end
        S_RUN: begin
          if (w_term) begin
            // Two or more survivors at termination can only mean the limit hit.
            r_win <= w_win;
            r_max <= (w_nz == '0) ? '0 : r_orig[w_win];
            r_nw  <= (w_nz == '0);
            r_tie <= (w_nz >= NZW'(2));
          end else begin
            for (int i = 0; i < N; i++) begin
              r_a[i] <= w_upd[i];
            end
            r_iter <= r_iter + IW'(1);
          end
        end
        default: begin
          r_iter <= r_iter;
        end
      endcase
    end
  end

  assign output_maximum_number = r_max;
  assign winner_index          = r_win;
  assign done                  = r_done;
  assign busy                  = r_busy;
  assign tie_timeout           = r_tie;
  assign no_winner             = r_nw;
  assign iter_count            = r_iter;

endmodule

// File: tb/tb_maxnet_param.sv
module tb_maxnet_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        start4, start8;
  logic [19:0] nin4;
  logic [63:0] nin8;

  logic [4:0]  max4;
  logic [1:0]  idx4;
  logic        done4, busy4, tie4, nw4;
  logic [3:0]  iter4;

  logic [7:0]  max8;
  logic [2:0]  idx8;
  logic        done8, busy8, tie8, nw8;
  logic [3:0]  iter8;

  int n_cmp = 0;
  int n_err = 0;

  maxnet_param #(.N(4), .WIDTH(5), .EPS_SHIFT(2), .MAX_ITER(15)) dut4 (
    .clock(clock), .reset(reset), .start_signal(start4), .neurons_in(nin4),
    .output_maximum_number(max4), .winner_index(idx4), .done(done4),
    .busy(busy4), .tie_timeout(tie4), .no_winner(nw4), .iter_count(iter4)
  );

  maxnet_param #(.N(8), .WIDTH(8), .EPS_SHIFT(3), .MAX_ITER(15)) dut8 (
    .clock(clock), .reset(reset), .start_signal(start8), .neurons_in(nin8),
    .output_maximum_number(max8), .winner_index(idx8), .done(done8),
    .busy(busy8), .tie_timeout(tie8), .no_winner(nw8), .iter_count(iter8)
  );

  typedef struct {
    logic [19:0] vin;   // {n3, n2, n1, n0}
    int          emax;
    int          eidx;
    int          eiter;
    int          etie;
    int          enw;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: whole-array MAXNET iteration with integer arithmetic.
  task automatic model(input int n, input int eps, input int maxit, input int v[8],
                       output int win, output int val, output int it,
                       output int tie, output int nw);
    int a[8];
    int nx[8];
    int s, cnt, inh;
    a  = v;
    it = 0;
    cnt = 0;
    for (int k = 0; k <= maxit + 1; k++) begin
      cnt = 0;
      s   = 0;
      for (int i = 0; i < n; i++) begin
        if (a[i] != 0) cnt++;
        s += a[i];
      end
      if (cnt <= 1 || it == maxit) break;
      for (int i = 0; i < n; i++) begin
        inh   = (s - a[i]) >> eps;
        nx[i] = (inh >= a[i]) ? 0 : a[i] - inh;
      end
      for (int i = 0; i < n; i++) a[i] = nx[i];
      it++;
    end
    win = 0;
    for (int i = n - 1; i >= 0; i--) if (a[i] != 0) win = i;
    val = (cnt == 0) ? 0 : v[win];
    tie = (cnt >= 2) ? 1 : 0;
    nw  = (cnt == 0) ? 1 : 0;
  endtask

  task automatic launch4(input logic [19:0] v);
    nin4   = v;
    start4 = 1'b1;
    @(posedge clock); #1;
    start4 = 1'b0;
  endtask

  task automatic launch8(input logic [63:0] v);
    nin8   = v;
    start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
  endtask

  // Cycles after the launch edge until done is seen (bounded).
  task automatic wait4(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock); #1;
      cyc++;
    end while (!done4 && cyc < 40);
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock); #1;
      cyc++;
    end while (!done8 && cyc < 40);
  endtask

  initial begin
    int cyc, win, val, it, tie, nw, mpos, vmax, amax;
    int v[8];
    logic [19:0] p4;
    logic [63:0] p8;

    tbl[0] = '{vin: {5'd2, 5'd8, 5'd2, 5'd2},   emax: 8,  eidx: 2, eiter: 1,  etie: 0, enw: 0};
    tbl[1] = '{vin: {5'd0, 5'd0, 5'd5, 5'd5},   emax: 5,  eidx: 0, eiter: 15, etie: 1, enw: 0};
    tbl[2] = '{vin: {5'd0, 5'd0, 5'd0, 5'd0},   emax: 0,  eidx: 0, eiter: 0,  etie: 0, enw: 1};
    tbl[3] = '{vin: {5'd6, 5'd12, 5'd3, 5'd9},  emax: 12, eidx: 2, eiter: 4,  etie: 0, enw: 0};
    tbl[4] = '{vin: {5'd0, 5'd0, 5'd30, 5'd31}, emax: 31, eidx: 0, eiter: 9,  etie: 0, enw: 0};

    reset  = 1'b1;
    start4 = 1'b0;
    start8 = 1'b0;
    nin4   = 20'h5A5A5;
    nin8   = 64'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_done", int'(done4), 0);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_max", int'(max4), 0);
    chk("rst_iter", int'(iter4), 0);
    chk("rst_flags", int'({tie4, nw4}), 0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("idle_no_start", int'({done4, busy4}), 0);

    // Directed table.
    for (int t = 0; t < 5; t++) begin
      launch4(tbl[t].vin);
      chk($sformatf("tbl%0d_busy", t), int'(busy4), 1);
      wait4(cyc);
      chk($sformatf("tbl%0d_latency", t), cyc, tbl[t].eiter + 1);
      chk($sformatf("tbl%0d_max", t), int'(max4), tbl[t].emax);
      chk($sformatf("tbl%0d_idx", t), int'(idx4), tbl[t].eidx);
      chk($sformatf("tbl%0d_iter", t), int'(iter4), tbl[t].eiter);
      chk($sformatf("tbl%0d_tie", t), int'(tie4), tbl[t].etie);
      chk($sformatf("tbl%0d_nw", t), int'(nw4), tbl[t].enw);
      chk($sformatf("tbl%0d_busy_end", t), int'(busy4), 0);
    end

    // Immediate DONE, then inputs change without start: result must hold.
    launch4({5'd0, 5'd31, 5'd0, 5'd0});
    wait4(cyc);
    chk("imm_latency", cyc, 1);
    chk("imm_max", int'(max4), 31);
    chk("imm_idx", int'(idx4), 2);
    chk("imm_iter", int'(iter4), 0);
    nin4 = {5'd31, 5'd1, 5'd7, 5'd20};
    repeat (3) @(posedge clock);
    #1;
    chk("hold_done", int'(done4), 1);
    chk("hold_max", int'(max4), 31);
    chk("hold_idx", int'(idx4), 2);

    // start pulsed mid-RUN is ignored; new inputs must not be picked up.
    launch4({5'd6, 5'd12, 5'd3, 5'd9});
    @(posedge clock); #1;
    start4 = 1'b1;
    nin4   = {5'd31, 5'd31, 5'd31, 5'd31};
    @(posedge clock); #1;
    start4 = 1'b0;
    chk("ign_busy", int'(busy4), 1);
    wait4(cyc);
    chk("ign_latency", cyc, 3);
    chk("ign_max", int'(max4), 12);
    chk("ign_idx", int'(idx4), 2);
    chk("ign_iter", int'(iter4), 4);

    // Reset in the middle of RUN.
    launch4({5'd0, 5'd0, 5'd5, 5'd5});
    repeat (3) begin @(posedge clock); #1; end
    chk("mid_busy", int'(busy4), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mrst_done", int'(done4), 0);
    chk("mrst_busy", int'(busy4), 0);
    chk("mrst_max", int'(max4), 0);
    chk("mrst_idx", int'(idx4), 0);
    chk("mrst_iter", int'(iter4), 0);
    chk("mrst_flags", int'({tie4, nw4}), 0);
    repeat (4) @(posedge clock);
    #1;
    chk("mrst_stay_idle", int'({done4, busy4}), 0);

    // Random N=4 vectors against the reference model.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 8; i++) v[i] = 0;
      for (int i = 0; i < 4; i++) begin
        v[i] = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(31, 0));
        p4[i*5 +: 5] = v[i][4:0];
      end
      model(4, 2, 15, v, win, val, it, tie, nw);
      launch4(p4);
      wait4(cyc);
      chk($sformatf("r4_%0d_latency", r), cyc, it + 1);
      chk($sformatf("r4_%0d_max", r), int'(max4), val);
      chk($sformatf("r4_%0d_idx", r), int'(idx4), win);
      chk($sformatf("r4_%0d_iter", r), int'(iter4), it);
      chk($sformatf("r4_%0d_flags", r), int'({tie4, nw4}), tie * 2 + nw);
    end

    // N=8, WIDTH=8, EPS_SHIFT=3: unique-max vectors.
    for (int r = 0; r < 30; r++) begin
      mpos = int'($urandom_range(7, 0));
      vmax = int'($urandom_range(255, 40));
      for (int i = 0; i < 8; i++) begin
        v[i] = (i == mpos) ? vmax : int'($urandom_range(vmax - 1, 0));
        p8[i*8 +: 8] = v[i][7:0];
      end
      amax = 0;
      for (int i = 1; i < 8; i++) if (v[i] > v[amax]) amax = i;
      model(8, 3, 15, v, win, val, it, tie, nw);
      launch8(p8);
      wait8(cyc);
      chk($sformatf("r8_%0d_latency", r), cyc, it + 1);
      chk($sformatf("r8_%0d_max", r), int'(max8), val);
      chk($sformatf("r8_%0d_idx", r), int'(idx8), win);
      chk($sformatf("r8_%0d_iter", r), int'(iter8), it);
      chk($sformatf("r8_%0d_flags", r), int'({tie8, nw8}), tie * 2 + nw);
      chk($sformatf("r8_%0d_iter_bound", r), (int'(iter8) <= 15) ? 1 : 0, 1);
      if (tie == 0) begin
        chk($sformatf("r8_%0d_argmax", r), int'(idx8), amax);
        chk($sformatf("r8_%0d_maxval", r), int'(max8), vmax);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
